// File: rtl/div_issue_ctrl_if.sv
// Handshake between the EX-stage divide controller and the iterative divider.
// The controller drives start/annul/operands; the divider returns ready/result.
interface div_issue_ctrl_if;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        div_ready_i;
  logic [63:0] div_result_i;

  modport master (
    output div_start_o,
    output div_annul_o,
    output div_signed_o,
    output div_op1_o,
    output div_op2_o,
    input  div_ready_i,
    input  div_result_i
  );

  modport slave (
    input  div_start_o,
    input  div_annul_o,
    input  div_signed_o,
    input  div_op1_o,
    input  div_op2_o,
    output div_ready_i,
    output div_result_i
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the 32-cycle iterative divider: latches operands, stalls
// the pipe while the divide runs and stages HI/LO until the instruction leaves EX.
module div_issue_ctrl #(
  parameter int TIMEOUT = 48,
  parameter int CNT_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_req_i,
  input  logic                    div_signed_i,
  input  logic [31:0]             op1_i,
  input  logic [31:0]             op2_i,
  input  logic                    ex_adv_i,
  input  logic                    flush_i,
  output logic                    stall_o,
  output logic                    hilo_we_o,
  output logic [31:0]             hi_o,
  output logic [31:0]             lo_o,
  output logic                    busy_o,
  output logic                    err_o,
  div_issue_ctrl_if.master        div
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_d;
  logic              start_q, start_d;
  logic              annul_q, annul_d;
  logic              err_q, err_d;
  logic              sign_q, sign_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall_c;
  logic              hilo_we_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      annul_q <= 1'b0;
      err_q   <= 1'b0;
      sign_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_d;
      start_q <= start_d;
      annul_q <= annul_d;
      err_q   <= err_d;
      sign_q  <= sign_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Annul and err are single-cycle pulses, so they default low every cycle.
  always_comb begin
    state_d   = state;
    start_d   = start_q;
    annul_d   = 1'b0;
    err_d     = 1'b0;
    sign_d    = sign_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    hilo_we_c = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (div_req_i && !flush_i) begin
          sign_d  = div_signed_i;
          op1_d   = op1_i;
          op2_d   = op2_i;
          start_d = 1'b1;
          stall_c = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // Flush beats a same-cycle ready: the killed instruction must not commit.
        if (flush_i) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          state_d = IDLE;
        end else if (div.div_ready_i) begin
          hi_d    = div.div_result_i[63:32];
          lo_d    = div.div_result_i[31:0];
          start_d = 1'b0;
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          start_d = 1'b0;
          annul_d = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      HOLD: begin
        start_d   = 1'b0;
        hilo_we_c = ex_adv_i && !flush_i;
        if (ex_adv_i || flush_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign stall_o          = stall_c;
  assign hilo_we_o        = hilo_we_c;
  assign hi_o             = hi_q;
  assign lo_o             = lo_q;
  assign busy_o           = (state != IDLE);
  assign err_o            = err_q;

  assign div.div_start_o  = start_q;
  assign div.div_annul_o  = annul_q;
  assign div.div_signed_o = sign_q;
  assign div.div_op1_o    = op1_q;
  assign div.div_op2_o    = op2_q;

endmodule
